// File: rtl/serial_lane_rx.sv
// Single-lane serial receiver: shifts in one bit per clk_32f cycle (MSB first),
// locks byte phase onto a run of COM symbols, then strobes out every non-COM byte.
module serial_lane_rx #(
   parameter logic [7:0] COM        = 8'hBC,
   parameter int         SYNC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [2:0] SYNC_TGT = SYNC_COUNT[2:0];

   // Only the newest seven bits are kept: the eighth bit of the word under
   // test is always the bit currently on serial_in.
   logic [6:0] r_sr;
   logic [2:0] r_bitCnt;
   logic [2:0] r_comCnt;
   state_t     r_state;

   logic [7:0] w_word;
   logic       w_isCom;
   logic       w_boundary;

   assign w_word     = {r_sr, serial_in};
   assign w_isCom    = (w_word == COM);
   assign w_boundary = (r_bitCnt == 3'd7);

   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         r_sr      <= '0;
         r_bitCnt  <= '0;
         r_comCnt  <= '0;
         r_state   <= ST_SEARCH;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         r_sr      <= w_word[6:0];
         r_bitCnt  <= r_bitCnt + 3'd1;
         valid_out <= 1'b0;

         case (r_state)
            // Any bit phase may match here; the first match fixes the phase.
            ST_SEARCH: begin
               if (w_isCom) begin
                  r_bitCnt <= 3'd0;
                  r_comCnt <= 3'd1;
                  if (SYNC_TGT == 3'd1) begin
                     r_state <= ST_ACTIVE;
                     active  <= 1'b1;
                  end else begin
                     r_state <= ST_ALIGN;
                  end
               end
            end

            ST_ALIGN: begin
               if (w_boundary) begin
                  if (w_isCom) begin
                     r_comCnt <= r_comCnt + 3'd1;
                     if (r_comCnt + 3'd1 == SYNC_TGT) begin
                        r_state <= ST_ACTIVE;
                        active  <= 1'b1;
                     end
                  end else begin
                     r_comCnt <= 3'd0;
                     r_state  <= ST_SEARCH;
                  end
               end
            end

            // Locked until reset; COM bytes are idle fill and leave data_out alone.
            ST_ACTIVE: begin
               if (w_boundary && !w_isCom) begin
                  data_out  <= w_word;
                  valid_out <= 1'b1;
               end
            end

            default: begin
               r_state  <= ST_SEARCH;
               r_comCnt <= 3'd0;
               active   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_lane_rx.sv
// Directed, table-driven bench for serial_lane_rx: byte-level vectors with
// expected strobe/data/active at each byte's final bit, plus reset corner cases.
module tb_serial_lane_rx;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       serial_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int testsRun = 0;
   int testsFailed = 0;

   serial_lane_rx #(.COM(8'hBC), .SYNC_COUNT(4)) dut (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .serial_in(serial_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .active   (active)
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      bit         doReset;
      int         preBits;
      logic [7:0] byteIn;
      logic       expValid;
      logic [7:0] expData;
      logic       expActive;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(bit rst, int pre, logic [7:0] b,
                                  logic v, logic [7:0] d, logic a);
      vec_t e;
      e.doReset   = rst;
      e.preBits   = pre;
      e.byteIn    = b;
      e.expValid  = v;
      e.expData   = d;
      e.expActive = a;
      vecs.push_back(e);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One bit per call; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic b);
      serial_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, output int earlyStrobes);
      earlyStrobes = 0;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(b[i]);
         if (i != 0 && valid_out === 1'b1) earlyStrobes++;
      end
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b0;
      for (int i = 0; i < cycles; i++) applyStimulus(1'($urandom_range(0, 1)));
      reset = 1'b1;
   endtask

   initial begin
      int early;
      int strobes;

      // Alignment with a 3-bit phase offset before the first COM.
      addVec(1, 3, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 1);
      addVec(0, 0, 8'h5A, 1, 8'h5A, 1);
      addVec(0, 0, 8'hC3, 1, 8'hC3, 1);
      // Broken sync: a data byte during ALIGN forces a fresh search.
      addVec(1, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'h11, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 1);
      addVec(0, 0, 8'h22, 1, 8'h22, 1);
      // Idle COMs in ACTIVE hold data_out; 7C and 00 are ordinary data.
      addVec(1, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 1);
      addVec(0, 0, 8'hA5, 1, 8'hA5, 1);
      addVec(0, 0, 8'hBC, 0, 8'hA5, 1);
      addVec(0, 0, 8'hBC, 0, 8'hA5, 1);
      addVec(0, 0, 8'h7C, 1, 8'h7C, 1);
      addVec(0, 0, 8'h00, 1, 8'h00, 1);
      // Back-to-back data, one strobe every 8 cycles.
      addVec(1, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 0);
      addVec(0, 0, 8'hBC, 0, 8'h00, 1);
      for (int v = 0; v < 16; v++) addVec(0, 0, 8'(v), 1, 8'(v), 1);

      $display("[TB] reset hold with random serial_in");
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'($urandom_range(0, 1)));
         checkOutput("reset_data", data_out, 8'h00);
         checkOutput("reset_valid", {7'd0, valid_out}, 8'h00);
         checkOutput("reset_active", {7'd0, active}, 8'h00);
      end
      reset = 1'b1;

      $display("[TB] table vectors: %0d bytes", vecs.size());
      foreach (vecs[n]) begin
         if (vecs[n].doReset) doReset(2);
         for (int p = 0; p < vecs[n].preBits; p++)
            applyStimulus(1'($urandom_range(0, 1)));
         sendByte(vecs[n].byteIn, early);
         checkOutput($sformatf("vec%0d_early_strobe", n), 8'(early), 8'h00);
         checkOutput($sformatf("vec%0d_valid", n), {7'd0, valid_out}, {7'd0, vecs[n].expValid});
         checkOutput($sformatf("vec%0d_data", n), data_out, vecs[n].expData);
         checkOutput($sformatf("vec%0d_active", n), {7'd0, active}, {7'd0, vecs[n].expActive});
      end

      $display("[TB] reset mid-byte in ACTIVE");
      doReset(2);
      for (int i = 0; i < 4; i++) sendByte(8'hBC, early);
      sendByte(8'h5A, early);
      checkOutput("mid_pre_data", data_out, 8'h5A);
      checkOutput("mid_pre_active", {7'd0, active}, 8'h01);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      reset = 1'b0;
      applyStimulus(1'b1);
      checkOutput("mid_rst_data", data_out, 8'h00);
      checkOutput("mid_rst_valid", {7'd0, valid_out}, 8'h00);
      checkOutput("mid_rst_active", {7'd0, active}, 8'h00);
      reset = 1'b1;
      strobes = 0;
      for (int i = 0; i < 3; i++) begin
         logic [7:0] pattern [3];
         pattern[0] = 8'h12;
         pattern[1] = 8'h34;
         pattern[2] = 8'h56;
         for (int k = 7; k >= 0; k--) begin
            applyStimulus(pattern[i][k]);
            if (valid_out === 1'b1) strobes++;
         end
      end
      checkOutput("post_rst_strobes", 8'(strobes), 8'h00);
      checkOutput("post_rst_active", {7'd0, active}, 8'h00);
      checkOutput("post_rst_data", data_out, 8'h00);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/serial_lane_rx.md
# serial_lane_rx

Single-lane serial receiver: deserializes one lane of the PHY serial bus (MSB first, one bit per `clk_32f` cycle), aligns to the 0xBC COM symbol, and delivers 8-bit data bytes with a one-cycle valid strobe. It is the receiving end of one transmitter lane and runs entirely in the `clk_32f` domain. Byte timing comes from an internal bit counter, with no divided clocks. Two instances serve `bus_serial_0` and `bus_serial_1` feeding the lane-merge logic.

## Interface
Parameters:
- COM, 8'hBC, alignment/idle symbol; transmitted when no valid data.
- SYNC_COUNT, 4, consecutive COM symbols required to declare the lane active (legal 1..7).

Ports:
- clk_32f  input  1  serial bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled on `clk_32f` rising edge.
- serial_in  input  1  serial lane data, MSB of each byte first.
- data_out  output  8  last received non-COM byte; holds between updates.
- valid_out  output  1  one-cycle strobe; `data_out` is new this cycle.
- active  output  1  lane aligned; SYNC_COUNT COMs seen.

## Operation
- Shift register `sr[7:0]` shifts every cycle: `sr <= {sr[6:0], serial_in}`; word under test `w = {sr[6:0], serial_in}` (combinational).
- Bit counter `bit_cnt[2:0]` wraps 7->0; a byte boundary is a cycle with `bit_cnt == 7` in ALIGN/ACTIVE.
- COM counter `com_cnt[2:0]`, saturates at SYNC_COUNT.
- States:
  - SEARCH: compare `w` to COM every cycle (any bit phase). On match: `bit_cnt <= 0`, `com_cnt <= 1`, go ALIGN (or ACTIVE directly if SYNC_COUNT==1). Otherwise remain.
  - ALIGN: at each boundary, if `w == COM` then `com_cnt++`; when it reaches SYNC_COUNT go ACTIVE. If `w != COM`, `com_cnt <= 0`, go SEARCH (bit phase discarded).
  - ACTIVE: at each boundary, if `w != COM` then `data_out <= w`, `valid_out <= 1`; if `w == COM`, no strobe, `data_out` unchanged. Remains ACTIVE until reset; no loss-of-sync detection in this block.
- `active` = registered (state == ACTIVE).
- Any byte value other than COM, including 8'h00 and 8'h7C, is data in ACTIVE.

## Timing
- Reset (reset==0 at a rising edge): state SEARCH, `sr`=0, `bit_cnt`=0, `com_cnt`=0, `data_out`=8'h00, `valid_out`=0, `active`=0. Reset has priority over all events, including mid-byte in ACTIVE. Alignment is lost and a full resync is required.
- All outputs registered. If the last bit of a byte is on `serial_in` at edge k, `data_out`/`valid_out` are updated at edge k and visible k..k+1. `valid_out` is high exactly one cycle. Maximum rate is one strobe per 8 cycles.
- `active` rises on the edge where the SYNC_COUNT-th COM's last bit is sampled. The first data strobe is possible 8 cycles later.
- A COM match in SEARCH that straddles a bit-phase shift is accepted. The first match defines the phase.
- First cycle after reset release: `sr` contains zeros, so no false COM is possible until 8 bits have been shifted.

## Test plan
- Reset: hold reset=0 with random `serial_in` for 20 cycles -> `data_out`=00, `valid_out`=0, `active`=0 throughout.
- Alignment: 3 random bits, then BC×4, then 0x5A, 0xC3 -> `active` rises on the last bit of the 4th BC. `valid_out` pulses 8 and 16 cycles later with `data_out`=5A then C3.
- Broken sync: BC, BC, 0x11, BC×4, 0x22 -> no `active` after the 0x11, which returns the block to SEARCH. `active` asserts after the next 4 BCs. Single strobe with 22.
- Idle in ACTIVE: after sync, 0xA5, BC, BC, 0x7C -> strobes for A5 and 7C only. `data_out` holds A5 through the BCs.
- Back-to-back: after sync, 0x00..0x0F continuous -> 16 strobes exactly 8 cycles apart, values in order.
- Reset mid-byte: in ACTIVE, assert reset after bit 4 of a data byte -> next cycle all outputs at reset values. Following data without BC produces no strobe.
